// File: rtl/move_rate_limiter.sv
// -----------------------------------------------------------------------------
// move_rate_limiter
//
// Turns raw paddle/menu button levels into single-cycle move pulses, one
// independent channel per button. Every press is followed by a minimum lockout
// window in which a release and re-press is ignored. When REPEAT_EN is set, a
// held button auto-repeats: the first repeat comes REPEAT_DELAY cycles after
// the press pulse, and later repeats come every REPEAT_PERIOD cycles.
//
// Ports:
//   fingclock  in   1         system clock, the only clock
//   rst_n      in   1         asynchronous active-low reset
//   enable     in   1         global enable; low forces every channel to IDLE
//   btn        in   CHANNELS  raw button levels, asynchronous to fingclock
//   pulse      out  CHANNELS  registered one-cycle move pulse per channel
//   busy       out  CHANNELS  registered, channel is not in IDLE
//   repeating  out  CHANNELS  registered, channel is in REPEAT
// -----------------------------------------------------------------------------
module move_rate_limiter #(
   parameter int CHANNELS      = 4,
   parameter int CNT_W         = 26,
   parameter int LOCKOUT       = 62500000,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                fingclock,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] repeating
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK   = 2'd1,
      REPEAT = 2'd2
   } state_e;

   // Counter values at which each decision is taken. The counter starts at 0
   // in the cycle right after a pulse, so a value of N-1 means N cycles have
   // elapsed since that pulse.
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCKOUT - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] btnSync;

   state_e              state_q  [CHANNELS];
   state_e              state_d  [CHANNELS];
   logic [CNT_W-1:0]    cnt_q    [CHANNELS];
   logic [CNT_W-1:0]    cnt_d    [CHANNELS];
   logic [CNT_W-1:0]    cntSat   [CHANNELS];

   logic [CHANNELS-1:0] pulse_q;
   logic [CHANNELS-1:0] pulse_d;
   logic [CHANNELS-1:0] busy_q;
   logic [CHANNELS-1:0] busy_d;
   logic [CHANNELS-1:0] repeating_q;
   logic [CHANNELS-1:0] repeating_d;

   // Synchronizer chain. The buttons are asynchronous to fingclock, so each
   // one is passed through SYNC_STAGES flops before anything looks at it; only
   // the last stage feeds the state machines.
   always_ff @(posedge fingclock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= btn;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign btnSync = sync_q[SYNC_STAGES-1];

   // Saturating increment of each channel counter. With repeat disabled a
   // channel can sit in LOCK for as long as the button is held, so the counter
   // must stick at its maximum instead of wrapping back below LOCK_LAST.
   always_comb begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
         cntSat[ch] = (cnt_q[ch] == CNT_MAX) ? cnt_q[ch] : cnt_q[ch] + CNT_ONE;
      end
   end

   // Per-channel next-state logic. A release is acted on only once the lockout
   // has elapsed, so a quick release/re-press inside the lockout looks like a
   // continuous hold. Repeat pulses need the button held at the exact count,
   // which keeps the repeat spacing fixed. Dropping enable overrides everything
   // and parks the channel in IDLE, so a button still held on re-enable fires
   // as a fresh press.
   always_comb begin
      pulse_d     = '0;
      busy_d      = '0;
      repeating_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         state_d[ch] = state_q[ch];
         cnt_d[ch]   = cnt_q[ch];
         if (!enable) begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
         end else begin
            unique case (state_q[ch])
               IDLE: begin
                  if (btnSync[ch]) begin
                     pulse_d[ch] = 1'b1;
                     cnt_d[ch]   = '0;
                     state_d[ch] = LOCK;
                  end
               end
               LOCK: begin
                  if (!btnSync[ch] && (cnt_q[ch] >= LOCK_LAST)) begin
                     cnt_d[ch]   = '0;
                     state_d[ch] = IDLE;
                  end else if ((REPEAT_EN != 0) && btnSync[ch] && (cnt_q[ch] == DELAY_LAST)) begin
                     pulse_d[ch] = 1'b1;
                     cnt_d[ch]   = '0;
                     state_d[ch] = REPEAT;
                  end else begin
                     cnt_d[ch] = cntSat[ch];
                  end
               end
               REPEAT: begin
                  if (btnSync[ch] && (cnt_q[ch] == PERIOD_LAST)) begin
                     pulse_d[ch] = 1'b1;
                     cnt_d[ch]   = '0;
                  end else if (!btnSync[ch] && (cnt_q[ch] >= LOCK_LAST)) begin
                     cnt_d[ch]   = '0;
                     state_d[ch] = IDLE;
                  end else begin
                     cnt_d[ch] = cntSat[ch];
                  end
               end
               default: begin
                  cnt_d[ch]   = '0;
                  state_d[ch] = IDLE;
               end
            endcase
         end
         busy_d[ch]      = (state_d[ch] != IDLE);
         repeating_d[ch] = (state_d[ch] == REPEAT);
      end
   end

   // State, counter and output registers. busy and repeating are registered
   // from the next state so they change on the same edge as the state itself,
   // which makes busy high during the pulse cycle.
   always_ff @(posedge fingclock or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            cnt_q[ch]   <= '0;
         end
         pulse_q     <= '0;
         busy_q      <= '0;
         repeating_q <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
         repeating_q <= repeating_d;
      end
   end

   assign pulse     = pulse_q;
   assign busy      = busy_q;
   assign repeating = repeating_q;

endmodule
